// File: rtl/fft_bin_writer.sv
// Write side of the per-frame FFT buffer: streams four channels of bins into the
// bin RAMs and tracks the channel-1 peak. Optional build macro: PEAK_THRESH_EN.
module fft_bin_writer #(
  parameter int NPOINTS = 1024,
  parameter int BINLO   = 1,
  parameter int BINHI   = 511,
  parameter int THRESH  = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sink_valid,
  input  logic        sink_sop,
  input  logic        sink_eop,
  input  logic [23:0] ch1d,
  input  logic [23:0] ch2d,
  input  logic [23:0] ch3d,
  input  logic [23:0] ch4d,
  input  logic        done,
  output logic        wren,
  output logic [9:0]  wraddr,
  output logic [23:0] ram1d,
  output logic [23:0] ram2d,
  output logic [23:0] ram3d,
  output logic [23:0] ram4d,
  output logic        detectdone,
  output logic [9:0]  maxbin,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CAPTURE,
    S_FLUSH,
    S_REPORT,
    S_HOLD
  } state_t;

  localparam logic [10:0] LAST_C   = 11'(NPOINTS - 1);
  localparam logic [9:0]  BINLO_C  = 10'(BINLO);
  localparam logic [9:0]  BINHI_C  = 10'(BINHI);
  localparam logic [12:0] THRESH_C = 13'(THRESH);

  state_t      state_q, state_d;
  logic [10:0] count_q, count_d;
  logic        wren_q, wren_d;
  logic [9:0]  wraddr_q, wraddr_d;
  logic [12:0] peak_mag_q, peak_mag_d;
  logic [9:0]  peak_bin_q, peak_bin_d;
  logic [9:0]  maxbin_q, maxbin_d;
  logic        detectdone_q, detectdone_d;

  logic        accept;
  logic        restart;
  logic        ram_load;
  logic [9:0]  sample_addr;
  logic        sample_in_range;
  logic [12:0] sample_mag;
  logic [12:0] base_mag;
  logic [9:0]  base_bin;
  logic        thresh_met;
  logic        report_ok;

  logic [95:0] ch_bus;
  logic [23:0] ch_data [4];
  logic [23:0] ramd_w  [4];

  function automatic logic [12:0] abs12(input logic [11:0] v);
    logic [12:0] ext;
    ext = {v[11], v};
    return v[11] ? (~ext + 13'd1) : ext;
  endfunction

  assign ch_bus = {ch4d, ch3d, ch2d, ch1d};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_ch
      logic [23:0] data_q;

      assign ch_data[gi] = ch_bus[gi*24 +: 24];

      always_ff @(posedge clk) begin
        if (reset) begin
          data_q <= '0;
        end else if (ram_load) begin
          data_q <= ch_data[gi];
        end
      end

      assign ramd_w[gi] = data_q;
    end
  endgenerate

  // |re| + |im| never overflows 13 bits, even for -2048 on both parts.
  assign sample_mag = abs12(ch_data[0][23:12]) + abs12(ch_data[0][11:0]);

  assign thresh_met = (peak_mag_q >= THRESH_C);

`ifdef PEAK_THRESH_EN
  assign report_ok = thresh_met;
`else
  logic unused_thresh;
  assign unused_thresh = thresh_met;
  assign report_ok     = 1'b1;
`endif

  always_comb begin
    state_d         = state_q;
    count_d         = count_q;
    wren_d          = 1'b0;
    wraddr_d        = wraddr_q;
    peak_mag_d      = peak_mag_q;
    peak_bin_d      = peak_bin_q;
    maxbin_d        = maxbin_q;
    detectdone_d    = 1'b0;
    accept          = 1'b0;
    restart         = 1'b0;
    ram_load        = 1'b0;
    sample_addr     = count_q[9:0];
    sample_in_range = 1'b0;
    base_mag        = peak_mag_q;
    base_bin        = peak_bin_q;

    case (state_q)
      S_IDLE: begin
        if (sink_valid && sink_sop) begin
          accept  = 1'b1;
          restart = 1'b1;
          state_d = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        if (sink_valid) begin
          accept = 1'b1;
          if (sink_sop) begin
            restart = 1'b1;
          end else if (sink_eop) begin
            // Only an eop landing exactly on the last bin completes a frame.
            state_d = (count_q == LAST_C) ? S_FLUSH : S_IDLE;
          end else if (count_q == LAST_C) begin
            state_d = S_IDLE;
          end
        end
      end
      S_FLUSH: begin
        state_d      = S_REPORT;
        detectdone_d = report_ok;
        if (report_ok) begin
          maxbin_d = peak_bin_q;
        end
      end
      S_REPORT: begin
        state_d = detectdone_q ? S_HOLD : S_IDLE;
      end
      S_HOLD: begin
        if (done) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (restart) begin
      sample_addr = '0;
      base_mag    = '0;
      base_bin    = BINLO_C;
    end

    if (accept) begin
      wren_d          = 1'b1;
      wraddr_d        = sample_addr;
      ram_load        = 1'b1;
      count_d         = {1'b0, sample_addr} + 11'd1;
      sample_in_range = (sample_addr >= BINLO_C) && (sample_addr <= BINHI_C);
      // Strict compare keeps the lowest bin on a tie.
      if (sample_in_range && (sample_mag > base_mag)) begin
        peak_mag_d = sample_mag;
        peak_bin_d = sample_addr;
      end else begin
        peak_mag_d = base_mag;
        peak_bin_d = base_bin;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      count_q      <= '0;
      wren_q       <= 1'b0;
      wraddr_q     <= '0;
      peak_mag_q   <= '0;
      peak_bin_q   <= BINLO_C;
      maxbin_q     <= '0;
      detectdone_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      wren_q       <= wren_d;
      wraddr_q     <= wraddr_d;
      peak_mag_q   <= peak_mag_d;
      peak_bin_q   <= peak_bin_d;
      maxbin_q     <= maxbin_d;
      detectdone_q <= detectdone_d;
    end
  end

  assign wren       = wren_q;
  assign wraddr     = wraddr_q;
  assign ram1d      = ramd_w[0];
  assign ram2d      = ramd_w[1];
  assign ram3d      = ramd_w[2];
  assign ram4d      = ramd_w[3];
  assign detectdone = detectdone_q;
  assign maxbin     = maxbin_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_fft_bin_writer.sv
// Scoreboard bench for fft_bin_writer: frame-level reference model, expected RAM
// writes and reports queued at stimulus time and checked by a separate monitor.
module tb_fft_bin_writer;

  localparam int NP  = 1024;
  localparam int BLO = 1;
  localparam int BHI = 511;
  localparam int TH  = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sink_valid = 1'b0;
  logic        sink_sop = 1'b0;
  logic        sink_eop = 1'b0;
  logic [23:0] ch1d = '0, ch2d = '0, ch3d = '0, ch4d = '0;
  logic        done = 1'b0;
  logic        wren;
  logic [9:0]  wraddr;
  logic [23:0] ram1d, ram2d, ram3d, ram4d;
  logic        detectdone;
  logic [9:0]  maxbin;
  logic        busy;

  fft_bin_writer #(
    .NPOINTS(NP), .BINLO(BLO), .BINHI(BHI), .THRESH(TH)
  ) dut (
    .clk(clk), .reset(reset),
    .sink_valid(sink_valid), .sink_sop(sink_sop), .sink_eop(sink_eop),
    .ch1d(ch1d), .ch2d(ch2d), .ch3d(ch3d), .ch4d(ch4d),
    .done(done),
    .wren(wren), .wraddr(wraddr),
    .ram1d(ram1d), .ram2d(ram2d), .ram3d(ram3d), .ram4d(ram4d),
    .detectdone(detectdone), .maxbin(maxbin), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct packed {
    int          cyc;
    logic [9:0]  addr;
    logic [95:0] data;
  } wr_t;

  typedef struct packed {
    int         cyc;
    logic [9:0] bin;
  } rep_t;

  wr_t  wq[$];
  rep_t rq[$];

  int n_checks = 0;
  int n_fail   = 0;

  logic [23:0] fr [4][NP];
  bit          holding = 1'b0;
  int          last_maxbin = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [23:0] mk(input int re, input int im);
    logic [11:0] r, i;
    r = re[11:0];
    i = im[11:0];
    return {r, i};
  endfunction

  function automatic int absv(input logic [11:0] v);
    int s;
    s = int'($signed(v));
    return (s < 0) ? -s : s;
  endfunction

  // Reference: argmax of |re|+|im| over channel 1 bins BLO..BHI, first bin wins ties.
  function automatic void ref_peak(output int bin, output int mag);
    bin = BLO;
    mag = 0;
    for (int b = BLO; b <= BHI; b++) begin
      int m;
      m = absv(fr[0][b][23:12]) + absv(fr[0][b][11:0]);
      if (m > mag) begin
        mag = m;
        bin = b;
      end
    end
  endfunction

  task automatic gen_frame(input int amp);
    for (int c = 0; c < 4; c++)
      for (int b = 0; b < NP; b++)
        fr[c][b] = mk(int'($urandom_range(0, 2*amp)) - amp,
                      int'($urandom_range(0, 2*amp)) - amp);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      sink_valid = 1'b0; sink_sop = 1'b0; sink_eop = 1'b0;
    end
  endtask

  task automatic junk(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      sink_valid = 1'b1; sink_sop = 1'b0; sink_eop = 1'b0;
      {ch1d, ch2d, ch3d, ch4d} = {$urandom, $urandom, $urandom};
    end
  endtask

  // Ends with the last sample (eop if requested) on the inputs during the current cycle.
  task automatic send_frame(input int len, input bit with_eop);
    bit live;
    bit rep;
    int bin, mag;
    live = !holding;
    for (int i = 0; i < len; i++) begin
      while ($urandom_range(0, 7) == 0) idle(1);
      @(posedge clk); #1;
      sink_valid = 1'b1;
      sink_sop   = (i == 0);
      sink_eop   = with_eop && (i == len - 1);
      {ch1d, ch2d, ch3d, ch4d} = {fr[0][i % NP], fr[1][i % NP], fr[2][i % NP], fr[3][i % NP]};
      if (live && i < NP)
        wq.push_back('{cyc: cyc + 1, addr: 10'(i), data: {ch1d, ch2d, ch3d, ch4d}});
    end
    rep = 1'b0;
    bin = BLO;
    if (live && with_eop && len == NP) begin
      ref_peak(bin, mag);
`ifdef PEAK_THRESH_EN
      rep = (mag >= TH);
`else
      rep = 1'b1;
`endif
      if (rep) begin
        rq.push_back('{cyc: cyc + 2, bin: 10'(bin)});
        holding     = 1'b1;
        last_maxbin = bin;
      end
    end
    $display("frame len=%0d eop=%0d live=%0d report=%0d bin=%0d", len, with_eop, live, rep, bin);
  endtask

  task automatic release_hold();
    idle(3);
    chk("busy_in_hold", busy, 1'b1);
    @(posedge clk); #1;
    done = 1'b1;
    @(posedge clk); #1;
    done = 1'b0;
    chk("busy_after_done", busy, 1'b0);
    holding = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_wren"}, wren, 1'b0);
    chk({tag, "_wraddr"}, wraddr, 10'd0);
    chk({tag, "_ram1d"}, ram1d, 24'd0);
    chk({tag, "_ram2d"}, ram2d, 24'd0);
    chk({tag, "_ram3d"}, ram3d, 24'd0);
    chk({tag, "_ram4d"}, ram4d, 24'd0);
    chk({tag, "_detectdone"}, detectdone, 1'b0);
    chk({tag, "_maxbin"}, maxbin, 10'd0);
    chk({tag, "_busy"}, busy, 1'b0);
  endtask

  // Monitor: consumes expected writes and reports as the DUT presents them.
  always @(negedge clk) begin
    if (wren) begin
      if (wq.size() == 0) begin
        chk("spurious_wren", wren, 1'b0);
      end else begin
        wr_t w;
        w = wq.pop_front();
        chk("wr_cycle", cyc, w.cyc);
        chk("wr_addr", wraddr, w.addr);
        chk("wr_data", {ram1d, ram2d, ram3d, ram4d}, w.data);
      end
    end else if (wq.size() > 0 && wq[0].cyc <= cyc) begin
      chk("missing_wren", wren, 1'b1);
      void'(wq.pop_front());
    end

    if (detectdone) begin
      $display("report cycle=%0d maxbin=%0d", cyc, maxbin);
      if (rq.size() == 0) begin
        chk("spurious_detectdone", detectdone, 1'b0);
      end else begin
        rep_t r;
        r = rq.pop_front();
        chk("report_cycle", cyc, r.cyc);
        chk("report_maxbin", maxbin, r.bin);
      end
    end else if (rq.size() > 0 && rq[0].cyc <= cyc) begin
      chk("missing_detectdone", detectdone, 1'b1);
      void'(rq.pop_front());
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    reset = 1'b0;

    // Ramp data with a dominant bin 200 on channel 1.
    for (int c = 0; c < 4; c++)
      for (int b = 0; b < NP; b++)
        fr[c][b] = mk(b, 0);
    fr[0][200] = mk(1000, -500);
    send_frame(NP, 1'b1);

    // A frame arriving during HOLD must not be written.
    gen_frame(2047);
    idle(4);
    send_frame(NP, 1'b1);
    release_hold();

    // Tie at 300 (bins 50, 80) plus a larger out-of-range bin; done in REPORT is ignored.
    gen_frame(2047);
    for (int b = 0; b < NP; b++) fr[0][b] = '0;
    fr[0][50]  = mk(300, 0);
    fr[0][80]  = mk(-100, -200);
    fr[0][700] = mk(2000, 0);
    send_frame(NP, 1'b1);
    idle(1);
    @(posedge clk); #1;
    done = 1'b1;
    @(posedge clk); #1;
    done = 1'b0;
    chk("done_in_report_ignored", busy, 1'b1);
    release_hold();

    // Samples without sop are dropped; short frame is discarded.
    junk(5);
    gen_frame(2047);
    send_frame(512, 1'b1);
    idle(1);
    chk("short_frame_idle", busy, 1'b0);
    chk("maxbin_held_short", maxbin, 10'(last_maxbin));

    // Extreme magnitude: -2048 on both parts gives 4096.
    gen_frame(2047);
    fr[0][300] = mk(-2048, -2048);
    send_frame(NP, 1'b1);
    release_hold();

    // Overlong frame: bins past the last address are ignored, no report.
    gen_frame(2047);
    send_frame(NP + 4, 1'b1);
    idle(1);
    chk("overlong_idle", busy, 1'b0);

    // Restart mid-frame: the big peak in the abandoned frame must not survive.
    gen_frame(200);
    fr[0][100] = mk(2047, 2047);
    send_frame(300, 1'b0);
    gen_frame(200);
    send_frame(NP, 1'b1);
    release_hold();

    // Peak magnitude one below the threshold.
    gen_frame(0);
    fr[0][10] = mk(40, -23);
    send_frame(NP, 1'b1);
`ifdef PEAK_THRESH_EN
    idle(3);
    chk("below_thresh_idle", busy, 1'b0);
    chk("maxbin_held_thresh", maxbin, 10'(last_maxbin));
`else
    release_hold();
`endif

    // Reset while bin 400 is presented.
    gen_frame(2047);
    send_frame(400, 1'b0);
    @(posedge clk); #1;
    reset      = 1'b1;
    sink_valid = 1'b1;
    sink_sop   = 1'b0;
    {ch1d, ch2d, ch3d, ch4d} = {fr[0][400], fr[1][400], fr[2][400], fr[3][400]};
    @(posedge clk); #1;
    chk_all_zero("midreset");
    reset      = 1'b0;
    sink_valid = 1'b0;
    holding    = 1'b0;

    // Recovery frame after reset.
    gen_frame(2047);
    idle(2);
    send_frame(NP, 1'b1);
    release_hold();

    idle(5);
    chk("write_queue_drained", wq.size(), 0);
    chk("report_queue_drained", rq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fft_bin_writer.md
# fft_bin_writer

Write side of the per-frame FFT buffer. It accepts a streamed 4-channel FFT frame, writes each channel's complex bins into the four bin RAMs, and finds the peak-magnitude bin on channel 1. When the frame is complete it pulses `detectdone` with `maxbin` and holds the RAMs frozen until the weighting/DOA stage returns `done`, at which point the next frame may be captured.

## Interface
Parameters:
- `NPOINTS`, 1024: bins per frame; address width is fixed at 10 bits.
- `BINLO`, 1: lowest bin included in the peak search (inclusive).
- `BINHI`, 511: highest bin included in the peak search (inclusive).
- `THRESH`, 64: minimum peak magnitude; used only when `PEAK_THRESH_EN` is defined.

Ports:
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `sink_valid` in 1: sample valid; one bin for all four channels per valid cycle.
- `sink_sop` in 1: marks bin 0; qualified by `sink_valid`.
- `sink_eop` in 1: marks the last bin; qualified by `sink_valid`.
- `ch1d`, `ch2d`, `ch3d`, `ch4d` in 24: bin data; [23:12] signed real, [11:0] signed imaginary.
- `done` in 1: consumer finished with the frame; a one-cycle pulse or a level.
- `wren` out 1: RAM write enable, common to all four RAMs.
- `wraddr` out 10: RAM write address.
- `ram1d`, `ram2d`, `ram3d`, `ram4d` out 24: RAM write data.
- `detectdone` out 1: one-cycle pulse; the frame is in the RAMs and `maxbin` is valid.
- `maxbin` out 10: peak bin of the last reported frame; held until the next report.
- `busy` out 1: high in every state except IDLE.

## Operation
- States: IDLE, CAPTURE, FLUSH, REPORT, HOLD.
- IDLE:
  - Accepts a sample only if it has `sink_valid` and `sink_sop` both high.
  - On that sample: write bin 0, clear the running peak, load the peak with bin 0's magnitude if bin 0 is in range, count = 1, go to CAPTURE.
  - Samples without sop are dropped.
- CAPTURE:
  - Each valid sample is written at address = count, then count increments.
  - Gaps in `sink_valid` are allowed.
- Magnitude:
  - mag = |re| + |im|, computed as 13-bit unsigned.
  - |−2048| = 2048, so the maximum is 4096 with no overflow.
- Peak search:
  - Considers only bins with BINLO ≤ addr ≤ BINHI.
  - Updates only on strict greater-than, so on a tie the lowest bin wins.
  - The peak register is initialised to magnitude 0, bin BINLO.
- Valid eop in CAPTURE:
  - When count+1 == NPOINTS, go to FLUSH.
  - Otherwise (short frame), discard the frame and go to IDLE. No `detectdone`.
- Overlong frame: if count reaches NPOINTS without an eop, discard and go to IDLE. Further samples are ignored until the next sop.
- sop in CAPTURE: restart the frame. This sample is written as bin 0, the peak and count are re-initialised, and the state stays CAPTURE.
- FLUSH: the last write commits, then go to REPORT.
- REPORT:
  - `detectdone` = 1 for this cycle and `maxbin` is updated.
  - With `PEAK_THRESH_EN`, see Configuration.
  - Go to HOLD.
- HOLD:
  - `wren` is held at 0 and all `sink_*` input is ignored, including sop; those frames are lost.
  - `done` = 1 sends the state to IDLE.
- `done` is sampled in HOLD only; in REPORT it is ignored.

## Timing
- Reset values: `wren` = 0, `wraddr` = 0, `ramNd` = 0, `detectdone` = 0, `maxbin` = 0, `busy` = 0, state IDLE.
- Write latency: a sample accepted in cycle t produces registered `wren`, `wraddr` and `ramNd` in cycle t+1.
- Report latency: eop accepted in cycle t gives the last `wren` at t+1 (FLUSH) and `detectdone` at t+2 (REPORT). The consumer may read from t+3.
- Release: `done` sampled in HOLD at cycle u gives IDLE at u+1. A sop at u+1 is accepted.
- Reset asserted mid-frame or in HOLD returns every output to its reset value on the next edge. The partial frame is abandoned.
- Minimum back-to-back frame period: NPOINTS + 3 cycles plus the consumer's HOLD time.

## Configuration
- `PEAK_THRESH_EN` defined:
  - In REPORT, if peak mag ≥ THRESH: `detectdone` pulses, `maxbin` updates, go to HOLD.
  - Otherwise: no pulse, `maxbin` unchanged, go directly to IDLE (the frame is discarded without a consumer handshake).
- `PEAK_THRESH_EN` undefined: every complete frame is reported, and the `THRESH` parameter is unused.

## Test plan
- Full frame, all channels with re = bin index and im = 0, plus ch1 bin 200 = {re 1000, im −500} → 1024 writes at addr 0..1023 with data matching; `detectdone` 2 cycles after eop; `maxbin` = 200.
- Equal magnitude 300 at bins 50 and 80, bin 700 = 2000 (out of range) → `maxbin` = 50.
- Short frame with eop at bin 511 → no `detectdone`, state IDLE; the next full frame reports correctly.
- Second frame arrives during HOLD → `wren` stays 0 throughout; `done` pulse → IDLE; the third frame is captured normally.
- sop re-asserted at bin 300 mid-frame, then a full frame → `wraddr` restarts at 0; peak taken from the new frame only.
- `PEAK_THRESH_EN` with peak mag 63, THRESH = 64 → no `detectdone`, `busy` low 3 cycles after eop; reset asserted at bin 400 of the following frame → all outputs 0 next edge.
